// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants for the clock-enable divider
package clk_div_pkg;

   localparam int NCH_DEF   = 4;
   localparam int DIV_W_DEF = 8;

   // Low bit of channel ch's ratio field inside the packed div bus.
   function automatic int div_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control/status bundle between divider and its user
interface clk_div_gen_if
   import clk_div_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DIV_W = DIV_W_DEF
);
   logic [NCH-1:0]       en;
   logic [NCH*DIV_W-1:0] div;
   logic                 sync;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       clk_out;
   logic [NCH-1:0]       running;

   modport master (output en, div, sync, input tick, clk_out, running);
   modport slave  (input en, div, sync, output tick, clk_out, running);
endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, shadow ratio, run flag
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DIV_W    = DIV_W_DEF,
   parameter bit GRACEFUL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             sync,
   output logic             tick,
   output logic             clk_out,
   output logic             running
);
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cur_div;
   logic             run;
   logic             at_end;

   assign at_end = (cnt == cur_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         cur_div <= '0;
         run     <= 1'b0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
         running <= 1'b0;
      end else begin
         tick    <= run & at_end;
         clk_out <= run & (cnt <= (cur_div >> 1));
         running <= run;
         if (!run) begin
            cnt     <= '0;
            cur_div <= div;
            run     <= en;
         // Stop is tested before sync so a stop boundary beats a re-align.
         end else if (!en && (!GRACEFUL || at_end)) begin
            run <= 1'b0;
            cnt <= '0;
         end else if (sync || at_end) begin
            cnt     <= '0;
            cur_div <= div;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end
endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel clock-enable / divided-clock generator
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int NCH      = NCH_DEF,
   parameter int DIV_W    = DIV_W_DEF,
   parameter bit GRACEFUL = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   clk_div_gen_if.slave bus
);
   logic [NCH-1:0] tick_v;
   logic [NCH-1:0] clk_out_v;
   logic [NCH-1:0] running_v;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam int LSB = div_lsb(i, DIV_W);

      clk_div_chan #(
         .DIV_W    (DIV_W),
         .GRACEFUL (GRACEFUL)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (bus.en[i]),
         .div     (bus.div[LSB +: DIV_W]),
         .sync    (bus.sync),
         .tick    (tick_v[i]),
         .clk_out (clk_out_v[i]),
         .running (running_v[i])
      );
   end

   assign bus.tick    = tick_v;
   assign bus.clk_out = clk_out_v;
   assign bus.running = running_v;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - scoreboard bench for clk_div_gen, graceful and abrupt stop
module tb_clk_div_gen;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  en;
   logic [3:0]  s_en;
   logic [31:0] div;
   logic        sync;

   int n_chk  = 0;
   int n_pass = 0;

   logic [11:0] exp_q [$];
   logic [11:0] exps_q [$];
   string       tag_q [$];

   localparam logic [2:0] OFF = 3'b000;

   always #5 clk = ~clk;

   clk_div_gen_if #(.NCH(4), .DIV_W(8)) g_if ();
   clk_div_gen_if #(.NCH(4), .DIV_W(8)) s_if ();

   assign g_if.en   = en;
   assign g_if.div  = div;
   assign g_if.sync = sync;
   assign s_if.en   = s_en;
   assign s_if.div  = div;
   assign s_if.sync = sync;

   clk_div_gen #(.NCH(4), .DIV_W(8), .GRACEFUL(1'b1)) u_dut_g (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (g_if)
   );

   clk_div_gen #(.NCH(4), .DIV_W(8), .GRACEFUL(1'b0)) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (s_if)
   );

   logic [11:0] got_g;
   logic [11:0] got_s;
   assign got_g = {g_if.tick, g_if.clk_out, g_if.running};
   assign got_s = {s_if.tick, s_if.clk_out, s_if.running};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // Channel outputs while running at phase ph of a period of p cycles: {tick, clk_out, running}.
   function automatic logic [2:0] ce(input int ph, input int p);
      return {ph == p - 1, ph < (p + 1) / 2, 1'b1};
   endfunction

   function automatic logic [11:0] pk(input logic [2:0] c0, input logic [2:0] c1,
                                      input logic [2:0] c2, input logic [2:0] c3);
      return {c3[2], c2[2], c1[2], c0[2], c3[1], c2[1], c1[1], c0[1],
              c3[0], c2[0], c1[0], c0[0]};
   endfunction

   task automatic cyc(input string tag, input logic [11:0] eg, input logic [11:0] es);
      logic [11:0] e_g;
      logic [11:0] e_s;
      string       t;
      exp_q.push_back(eg);
      exps_q.push_back(es);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e_g = exp_q.pop_front();
      e_s = exps_q.pop_front();
      t   = tag_q.pop_front();
      check({t, "_g"}, {20'd0, got_g}, {20'd0, e_g});
      check({t, "_s"}, {20'd0, got_s}, {20'd0, e_s});
   endtask

   task automatic do_reset();
      en    = '0;
      s_en  = '0;
      sync  = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] c0, c1, c2, c3;

      rst_n = 1'b0;
      en    = '0;
      s_en  = '0;
      div   = '0;
      sync  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_g", {20'd0, got_g}, 32'd0);
      check("rst_s", {20'd0, got_s}, 32'd0);

      // Reset/idle: ch2 running P=6, async reset mid-cycle, then idle release.
      rst_n = 1'b1;
      div   = 32'h0005_0000;
      en    = 4'b0100;
      for (int k = 0; k <= 8; k++) begin
         c2 = (k == 0) ? OFF : ce((k - 1) % 6, 6);
         cyc("t1_run", pk(OFF, OFF, c2, OFF), 12'd0);
      end
      #3;
      rst_n = 1'b0;
      #1;
      check("t1_async", {20'd0, got_g}, 32'd0);
      cyc("t1_hold", 12'd0, 12'd0);
      cyc("t1_hold", 12'd0, 12'd0);
      en    = '0;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) cyc("t1_idle", 12'd0, 12'd0);

      // Ratios P = 1, 2, 5, 256 all running together.
      do_reset();
      div = {8'd255, 8'd4, 8'd1, 8'd0};
      en  = 4'hf;
      for (int k = 0; k <= 520; k++) begin
         if (k == 0) begin
            c0 = OFF; c1 = OFF; c2 = OFF; c3 = OFF;
         end else begin
            c0 = ce(0, 1);
            c1 = ce((k - 1) % 2, 2);
            c2 = ce((k - 1) % 5, 5);
            c3 = ce((k - 1) % 256, 256);
         end
         cyc("t2_ratio", pk(c0, c1, c2, c3), 12'd0);
      end

      // Shadow: div 4 -> 9 mid-period takes effect only at the boundary.
      do_reset();
      div = 32'h0004_0000;
      en  = 4'b0100;
      for (int k = 0; k <= 30; k++) begin
         if (k == 3) div = 32'h0009_0000;
         if (k == 0)      c2 = OFF;
         else if (k <= 5) c2 = ce(k - 1, 5);
         else             c2 = ce((k - 6) % 10, 10);
         cyc("t3_shadow", pk(OFF, OFF, c2, OFF), 12'd0);
      end

      // Stop: en drops at cnt=3, graceful finishes the period, abrupt stops at once.
      do_reset();
      div  = 32'h0000_0700;
      en   = 4'b0010;
      s_en = 4'b0010;
      for (int k = 0; k <= 20; k++) begin
         if (k == 4) begin
            en   = '0;
            s_en = '0;
         end
         c1 = (k == 0 || k > 8) ? OFF : ce(k - 1, 8);
         c2 = (k == 0 || k > 4) ? OFF : ce(k - 1, 8);
         cyc("t4_stop", pk(OFF, c1, OFF, OFF), pk(OFF, c2, OFF, OFF));
      end

      // Sync: ch1 P=3 and ch2 P=5 out of phase, re-aligned at step 10.
      do_reset();
      div = {8'd0, 8'd4, 8'd2, 8'd0};
      en  = 4'b0010;
      for (int k = 0; k <= 22; k++) begin
         if (k == 1)  en = 4'b0110;
         if (k == 10) sync = 1'b1;
         if (k == 11) sync = 1'b0;
         if (k <= 10) begin
            c1 = (k == 0) ? OFF : ce((k - 1) % 3, 3);
            c2 = (k <= 1) ? OFF : ce((k - 2) % 5, 5);
         end else begin
            c1 = ce((k - 11) % 3, 3);
            c2 = ce((k - 11) % 5, 5);
         end
         cyc("t5_sync", pk(OFF, c1, c2, OFF), 12'd0);
      end

      // Corner: en dropped for one cycle before the boundary cancels the stop.
      do_reset();
      div = 32'h0000_0003;
      en  = 4'b0001;
      for (int k = 0; k <= 20; k++) begin
         if (k == 3) en = 4'b0000;
         if (k == 4) en = 4'b0001;
         c0 = (k == 0) ? OFF : ce((k - 1) % 4, 4);
         cyc("t6_cancel", pk(c0, OFF, OFF, OFF), 12'd0);
      end

      // Corner: sync lands on ch0's stop boundary; ch0 stops, ch2 re-aligns.
      do_reset();
      div = {8'd0, 8'd4, 8'd0, 8'd3};
      en  = 4'b0101;
      for (int k = 0; k <= 16; k++) begin
         if (k == 1) en = 4'b0100;
         if (k == 4) sync = 1'b1;
         if (k == 5) sync = 1'b0;
         c0 = (k == 0 || k > 4) ? OFF : ce(k - 1, 4);
         if (k == 0)      c2 = OFF;
         else if (k <= 4) c2 = ce(k - 1, 5);
         else             c2 = ce((k - 5) % 5, 5);
         cyc("t6_syncstop", pk(c0, OFF, c2, OFF), 12'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
